// File: rtl/ifetch_unit_if.sv
// Instruction-memory handshake between the fetch unit (master) and the
// instruction memory (slave). One request is outstanding at a time: the
// master raises mem_req with mem_addr and holds both until the slave
// answers with mem_ack and mem_data in the same cycle.
interface ifetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: captures the PC, issues one instruction-memory
// request at a time, and holds one fetched instruction for decode. A branch
// redirect (flush_i) discards the wrong-path fetch; a request already in
// flight is drained before the next one is issued.
// Optional build macro IFETCH_PERF_EN adds fetch/flush event counters.
module ifetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       pc_i,
  input  logic              flush_i,
  output logic              stall_o,
  ifetch_unit_if.master     mem,
  output logic [DATA_W-1:0] inst_o,
  output logic [31:0]       inst_pc_o,
  output logic              inst_valid_o,
  input  logic              id_ready_i
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,   // nothing in flight, output register empty
    S_WAIT,   // request in flight, response is wanted
    S_FULL,   // output register holds an instruction for decode
    S_DRAIN   // request in flight, response will be thrown away
  } state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              accept;

  // Stall back to the PC; a redirect always wins so the PC can load the target.
  always_comb begin
    stall_o = !flush_i && ((state_q == S_WAIT) || (state_q == S_DRAIN) ||
                           ((state_q == S_FULL) && !id_ready_i));
    accept  = !stall_o && !flush_i &&
              ((state_q == S_IDLE) || (state_q == S_FULL));
  end

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    unique case (state_q)
      S_IDLE: begin
        // Only an accept (handled below) leaves IDLE; flush is a no-op here.
      end
      S_WAIT: begin
        if (flush_i) begin
          inst_d = NOP_INST;
          if (mem.mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            state_d   = S_DRAIN;
          end
        end else if (mem.mem_ack) begin
          mem_req_d    = 1'b0;
          inst_d       = mem.mem_data;
          inst_pc_d    = 32'(mem_addr_q);
          inst_valid_d = 1'b1;
          state_d      = S_FULL;
        end
      end
      S_DRAIN: begin
        // Wrong-path response: drop the data and go idle.
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_FULL: begin
        if (flush_i) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
          state_d      = S_IDLE;
        end else if (id_ready_i) begin
          inst_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // New request; in FULL this overlaps with decode consuming the instruction.
    if (accept) begin
      mem_req_d  = 1'b1;
      mem_addr_d = pc_i[ADDR_W-1:0];
      state_d    = S_WAIT;
    end
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_addr  = mem_addr_q;
  assign inst_o        = inst_q;
  assign inst_pc_o     = inst_pc_q;
  assign inst_valid_o  = inst_valid_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counters: accepts, and redirects that hit live or draining work.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (accept ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q +
                  ((flush_i && (state_q != S_IDLE)) ? 32'd1 : 32'd0);
  end

  // Counter registers, wrapping naturally at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage that consumes the word address from the program counter and returns instructions to decode. Issues one outstanding request at a time on a variable-latency instruction-memory handshake and holds one fetched instruction in an output register. Drives the stall back to the PC so the PC holds its value while fetch is busy. Accepts the branch-redirect (flush) also seen by the PC and discards wrong-path fetches.

Parameters:
ADDR_W, 32, width of mem_addr_o; pc_i is truncated to its low ADDR_W bits.
DATA_W, 32, instruction width.
NOP_INST, {DATA_W{1'b0}}, value of inst_o at reset and after a flush.

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
rst_i  in  1  reset, asynchronous, active-high.
pc_i  in  32  word address from the PC.
flush_i  in  1  branch redirect, same signal that loads the PC target.
stall_o  out  1  to PC; the PC holds its value while this is 1.
mem_req_o  out  1  instruction-memory request.
mem_addr_o  out  ADDR_W  request word address.
mem_ack_i  in  1  memory response valid; sampled only while mem_req_o=1.
mem_data_i  in  DATA_W  response data, valid with mem_ack_i.
inst_o  out  DATA_W  fetched instruction.
inst_pc_o  out  32  address of inst_o.
inst_valid_o  out  1  inst_o valid for decode.
id_ready_i  in  1  decode consumes inst_o at an edge where inst_valid_o=1 and id_ready_i=1.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; mem_req_o=0, mem_addr_o=0, inst_o=NOP_INST, inst_pc_o=0, inst_valid_o=0. stall_o is 0 in IDLE.
- States: IDLE, WAIT, FULL, DRAIN. All outputs are registered except stall_o.
- stall_o = !flush_i & (WAIT | DRAIN | (FULL & !id_ready_i)). It is forced to 0 under flush_i so the PC takes the redirect.
- Accept: pc_i is captured at an edge where stall_o=0, flush_i=0, and the state is IDLE or FULL. The edge sets mem_addr_o=pc_i[ADDR_W-1:0], mem_req_o=1 and the state to WAIT.
- IDLE: accept if possible, else stay. flush_i has no effect.
- WAIT: mem_req_o=1 and mem_addr_o are held stable until an edge with mem_ack_i=1. At that edge:
  - mem_req_o<=0, inst_o<=mem_data_i, inst_pc_o<=the request address zero-extended to 32 bits, inst_valid_o<=1, state=FULL.
  - Minimum latency is accept edge N, then ack at edge N+1, so inst_valid_o=1 after edge N+1.
- WAIT with flush_i=1:
  - With mem_ack_i: data discarded, mem_req_o<=0, state=IDLE.
  - Without mem_ack_i: state=DRAIN.
- DRAIN: mem_req_o held until mem_ack_i; the data is discarded and the state goes to IDLE. Further flush_i in DRAIN stays in DRAIN.
- FULL with id_ready_i=1 and no flush: inst_valid_o<=0 and pc_i is accepted in the same edge (state=WAIT). This gives back-to-back fetch at one instruction per 2 cycles with single-cycle memory.
- FULL with id_ready_i=0: all outputs hold and the state stays FULL.
- FULL with flush_i=1: inst_valid_o<=0, inst_o<=NOP_INST, state=IDLE, no accept. Flush takes priority over consume and accept.
- mem_ack_i while mem_req_o=0 is ignored.
- Reset mid-request drops mem_req_o immediately. The memory side must tolerate the abandoned request.

Optional Feature:
IFETCH_PERF_EN
- Defined: adds ports fetch_cnt_o (out, 32) and flush_cnt_o (out, 32), both reset to 0.
  - fetch_cnt_o increments on every accept edge.
  - flush_cnt_o increments on every edge with flush_i=1 in WAIT, DRAIN or FULL.
  - Both wrap 0xFFFFFFFF to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then pc_i=0x10 and memory ack one cycle after req with data 0xDEADBEEF, id_ready_i=1 -> mem_addr_o=0x10 after edge 1; inst_o=0xDEADBEEF, inst_pc_o=0x10, inst_valid_o=1 after edge 2.
- Memory ack delayed 4 cycles -> mem_req_o and mem_addr_o stable for 4 cycles, stall_o=1 throughout, inst_valid_o=0 until the ack edge.
- FULL with id_ready_i=0 for 3 cycles -> inst_o, inst_pc_o and inst_valid_o stable and stall_o=1; raising id_ready_i gives stall_o=0 and the next pc_i accepted at that edge.
- flush_i in WAIT with ack 2 cycles later -> state DRAIN; stall_o=0 on the flush cycle then 1; returned data never appears on inst_o; next pc_i (target 0x40) fetched after DRAIN exits.
- flush_i coincident with mem_ack_i in WAIT, and flush_i in FULL -> inst_valid_o=0, inst_o=NOP_INST, no accept that edge.
- rst_i pulsed between clock edges during WAIT -> all outputs return to reset values immediately. With IFETCH_PERF_EN, 5 fetches and 2 flushes give fetch_cnt_o=5 and flush_cnt_o=2; reset clears both.
